// File: rtl/ahb_slave_arbiter.sv
// AHB-Lite slave-port arbiter: round-robin grant over four masters, held across
// locked sequences and bursts, with a data-phase select that follows accepted address phases.
module ahb_slave_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter bit          PARK_LAST      = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] Req,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HMASTLOCK,
    input  logic       HREADY,
    output logic [1:0] Master_Sel_A,
    output logic [1:0] Master_Sel_D,
    output logic [3:0] Grant,
    output logic       Data_Valid
);

    localparam int unsigned N_MASTERS = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned CNT_W     = 5;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;
    localparam logic [2:0] BURST_WRAP4  = 3'd2;
    localparam logic [2:0] BURST_INCR4  = 3'd3;
    localparam logic [2:0] BURST_WRAP8  = 3'd4;
    localparam logic [2:0] BURST_INCR8  = 3'd5;
    localparam logic [2:0] BURST_WRAP16 = 3'd6;
    localparam logic [2:0] BURST_INCR16 = 3'd7;

    localparam logic [SEL_W-1:0]     DEF_SEL   = SEL_W'(DEFAULT_MASTER);
    localparam logic [N_MASTERS-1:0] DEF_GRANT = N_MASTERS'(1) << DEF_SEL;

    logic [CNT_W-1:0]     beat_cnt;
    logic [CNT_W-1:0]     beat_cnt_nxt;
    logic [CNT_W-1:0]     burst_last;
    logic                 fixed_burst;
    logic                 lock_hold;
    logic                 burst_hold;
    logic                 arb_point;
    logic                 rr_found;
    logic [SEL_W-1:0]     rr_cand;
    logic [SEL_W-1:0]     rr_winner;
    logic [SEL_W-1:0]     sel_a_nxt;
    logic [N_MASTERS-1:0] grant_nxt;

    // Remaining beats loaded by a NONSEQ, by burst type
    always_comb begin
        unique case (HBURST)
            BURST_WRAP4,  BURST_INCR4:  burst_last = CNT_W'(3);
            BURST_WRAP8,  BURST_INCR8:  burst_last = CNT_W'(7);
            BURST_WRAP16, BURST_INCR16: burst_last = CNT_W'(15);
            default:                    burst_last = '0;
        endcase
    end

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (HREADY) begin
            unique case (HTRANS)
                TRANS_NONSEQ: beat_cnt_nxt = burst_last;
                TRANS_SEQ:    beat_cnt_nxt = (beat_cnt != '0) ? beat_cnt - CNT_W'(1) : '0;
                TRANS_IDLE:   beat_cnt_nxt = '0;
                TRANS_BUSY:   beat_cnt_nxt = beat_cnt;
            endcase
        end
    end

    // Hold evaluated against the counter value after this cycle's update
    always_comb begin
        fixed_burst = (HBURST != BURST_SINGLE) && (HBURST != BURST_INCR);
        lock_hold   = HMASTLOCK && (HTRANS != TRANS_IDLE);
        burst_hold  = (fixed_burst && (beat_cnt_nxt != '0))
                    || ((HBURST == BURST_INCR) && (HTRANS != TRANS_IDLE));
        arb_point   = HREADY && !lock_hold && !burst_hold;
    end

    // Round-robin scan starting after the current owner; the owner itself is checked last
    always_comb begin
        rr_found  = 1'b0;
        rr_cand   = '0;
        rr_winner = PARK_LAST ? Master_Sel_A : DEF_SEL;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            rr_cand = Master_Sel_A + SEL_W'(k);
            if (!rr_found && Req[rr_cand]) begin
                rr_winner = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a_nxt = arb_point ? rr_winner : Master_Sel_A;
        grant_nxt = N_MASTERS'(1) << sel_a_nxt;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            Master_Sel_A <= DEF_SEL;
            Master_Sel_D <= DEF_SEL;
            Grant        <= DEF_GRANT;
            Data_Valid   <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            beat_cnt     <= beat_cnt_nxt;
            Master_Sel_A <= sel_a_nxt;
            Grant        <= grant_nxt;
            if (HREADY) begin
                Master_Sel_D <= Master_Sel_A;
                Data_Valid   <= HTRANS[1];
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: two instances (parked / default-return) driven by directed
// scenarios and constrained-random AHB traffic, scored against a transaction-level model.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] WRAP4  = 3'd2;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] INCR8  = 3'd5;

    localparam int DEF_A = 0;
    localparam int DEF_B = 2;

    typedef struct {
        int owner;
        int dsel;
        bit dv;
        int left;
    } mstate_t;

    typedef struct {
        mstate_t a;
        mstate_t b;
    } exp_t;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [3:0] Req = '0;
    logic [1:0] HTRANS = IDLE;
    logic [2:0] HBURST = SINGLE;
    logic       HMASTLOCK = 1'b0;
    logic       HREADY = 1'b1;

    logic [1:0] sel_a_a, sel_d_a, sel_a_b, sel_d_b;
    logic [3:0] grant_a, grant_b;
    logic       dv_a, dv_b;

    int      checks = 0;
    int      failures = 0;
    exp_t    exp_q[$];
    mstate_t ma, mb;

    logic [1:0] g_tr = IDLE;
    logic [2:0] g_bu = SINGLE;
    logic       g_lk = 1'b0;
    int         g_left = 0;
    logic       last_rdy = 1'b1;

    ahb_slave_arbiter #(.DEFAULT_MASTER(DEF_A), .PARK_LAST(1'b1)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .Req(Req), .HTRANS(HTRANS), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .Master_Sel_A(sel_a_a),
        .Master_Sel_D(sel_d_a), .Grant(grant_a), .Data_Valid(dv_a)
    );

    ahb_slave_arbiter #(.DEFAULT_MASTER(DEF_B), .PARK_LAST(1'b0)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .Req(Req), .HTRANS(HTRANS), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .Master_Sel_A(sel_a_b),
        .Master_Sel_D(sel_d_b), .Grant(grant_b), .Data_Valid(dv_b)
    );

    always #5 HCLK = ~HCLK;

    // Beats in a burst: SINGLE/INCR count as one, fixed bursts are 4, 8 or 16
    function automatic int burst_len(logic [2:0] b);
        if (int'(b) < 2) return 1;
        return 4 << ((int'(b) - 2) / 2);
    endfunction

    // One clock of the arbiter as described by its transfer rules
    function automatic mstate_t step(mstate_t s, int dm, bit park, logic [3:0] req,
                                     logic [1:0] tr, logic [2:0] bu, logic lk, logic rdy);
        mstate_t n;
        bit      hold;
        n = s;
        if (!rdy) return n;
        n.dsel = s.owner;
        n.dv   = (tr == NONSEQ) || (tr == SEQ);
        if (tr == NONSEQ)    n.left = burst_len(bu) - 1;
        else if (tr == SEQ)  n.left = (s.left > 0) ? s.left - 1 : 0;
        else if (tr == IDLE) n.left = 0;
        hold = (lk && tr != IDLE) || (int'(bu) >= 2 && n.left > 0) || (bu == INCR && tr != IDLE);
        if (!hold) begin
            n.owner = park ? s.owner : dm;
            for (int d = 4; d >= 1; d--)
                if (req[(s.owner + d) % 4]) n.owner = (s.owner + d) % 4;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input mstate_t m, input logic [1:0] sa,
                              input logic [1:0] sd, input logic [3:0] g, input logic dv);
        chk({tag, ".sel_a"}, 32'(sa), m.owner);
        chk({tag, ".sel_d"}, 32'(sd), m.dsel);
        chk({tag, ".grant"}, 32'(g), 1 << m.owner);
        chk({tag, ".data_valid"}, 32'(dv), int'(m.dv));
    endtask

    // Async reset: outputs must reach reset values without any clock edge
    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        ma.owner = DEF_A; ma.dsel = DEF_A; ma.dv = 1'b0; ma.left = 0;
        mb.owner = DEF_B; mb.dsel = DEF_B; mb.dv = 1'b0; mb.left = 0;
        #1;
        check_inst("rst_a", ma, sel_a_a, sel_d_a, grant_a, dv_a);
        check_inst("rst_b", mb, sel_a_b, sel_d_b, grant_b, dv_b);
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                       input logic lk, input logic rdy);
        exp_t e;
        @(negedge HCLK);
        Req = req; HTRANS = tr; HBURST = bu; HMASTLOCK = lk; HREADY = rdy;
        ma = step(ma, DEF_A, 1'b1, req, tr, bu, lk, rdy);
        mb = step(mb, DEF_B, 1'b0, req, tr, bu, lk, rdy);
        e.a = ma;
        e.b = mb;
        exp_q.push_back(e);
    endtask

    // Burst-shaped random traffic; the transfer is held while HREADY was low
    task automatic rand_cyc();
        logic [3:0] req;
        logic       rdy;
        int         r;
        req = 4'($urandom);
        if ($urandom_range(0, 7) == 0) req = '0;
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
            cyc(req, 2'($urandom), 3'($urandom), 1'($urandom), rdy);
        end else begin
            if (last_rdy) begin
                if (g_left > 0) begin
                    r = $urandom_range(0, 19);
                    if (r == 0) begin
                        g_tr = IDLE; g_left = 0;
                    end else if (r < 3) begin
                        g_tr = BUSY;
                    end else begin
                        g_tr = SEQ; g_left--;
                    end
                end else if ($urandom_range(0, 9) < 3) begin
                    g_tr = IDLE;
                end else begin
                    g_tr   = NONSEQ;
                    g_bu   = 3'($urandom);
                    g_lk   = ($urandom_range(0, 4) == 0);
                    g_left = (g_bu == INCR) ? $urandom_range(0, 5) : burst_len(g_bu) - 1;
                end
            end
            cyc(req, g_tr, g_bu, g_lk, rdy);
        end
        last_rdy = HREADY;
    endtask

    // Monitor: every expected entry is compared one step after the edge that produced it
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_inst("a", e.a, sel_a_a, sel_d_a, grant_a, dv_a);
                check_inst("b", e.b, sel_a_b, sel_d_b, grant_b, dv_b);
            end
        end
    end

    initial begin
        do_reset();
        // round-robin with SINGLE transfers
        repeat (5) cyc(4'b1111, NONSEQ, SINGLE, 1'b0, 1'b1);
        // INCR4 from M1 with two wait states on beat 3
        cyc(4'b1111, NONSEQ, INCR4, 1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR4, 1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR4, 1'b0, 1'b0);
        cyc(4'b1111, SEQ,    INCR4, 1'b0, 1'b0);
        cyc(4'b1111, SEQ,    INCR4, 1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR4, 1'b0, 1'b1);
        // locked pair from M2, then an unlocked transfer
        cyc(4'b1111, NONSEQ, SINGLE, 1'b1, 1'b1);
        cyc(4'b1111, NONSEQ, SINGLE, 1'b1, 1'b1);
        cyc(4'b1111, NONSEQ, SINGLE, 1'b0, 1'b1);
        // hand to M0, then WRAP8 terminated early by IDLE
        cyc(4'b0001, IDLE,   SINGLE, 1'b0, 1'b1);
        cyc(4'b0110, NONSEQ, WRAP8,  1'b0, 1'b1);
        cyc(4'b0110, SEQ,    WRAP8,  1'b0, 1'b1);
        cyc(4'b0110, SEQ,    WRAP8,  1'b0, 1'b1);
        cyc(4'b0110, IDLE,   WRAP8,  1'b0, 1'b1);
        // hand to M3, then no requests (park vs default)
        cyc(4'b1000, IDLE,   SINGLE, 1'b0, 1'b1);
        repeat (3) cyc(4'b0000, IDLE, SINGLE, 1'b0, 1'b1);
        // INCR8 in flight when reset hits
        cyc(4'b1111, NONSEQ, INCR8, 1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR8, 1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR8, 1'b0, 1'b1);
        do_reset();
        cyc(4'b0100, NONSEQ, SINGLE, 1'b0, 1'b1);
        cyc(4'b0100, IDLE,   SINGLE, 1'b0, 1'b1);
        // also exercise BUSY inside an INCR burst and a fixed burst
        cyc(4'b1111, NONSEQ, INCR,  1'b0, 1'b1);
        cyc(4'b1111, BUSY,   INCR,  1'b0, 1'b1);
        cyc(4'b1111, SEQ,    INCR,  1'b0, 1'b1);
        cyc(4'b1111, IDLE,   INCR,  1'b0, 1'b1);
        cyc(4'b1111, NONSEQ, WRAP4, 1'b0, 1'b1);
        cyc(4'b1111, BUSY,   WRAP4, 1'b0, 1'b1);
        repeat (3) cyc(4'b1111, SEQ, WRAP4, 1'b0, 1'b1);

        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                last_rdy = 1'b1;
                g_left   = 0;
            end else begin
                rand_cyc();
            end
        end

        repeat (2) @(negedge HCLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
